i2s_master_tx: RTL

- Serializes left/right 24-bit PCM samples into a standard I2S stream and generates the I2S clocks itself.
- Master-mode transmitter: the opposite direction of the I2S-to-PCM receiver path.
- Sits between the processed-audio mux (equalizer output or sine generator) and the DAC output registers.
- Request strobes tell upstream when a channel's holding register has been consumed.

---
 rtl/audipus_audio_pkg.sv | 17 +
 rtl/i2s_clk_div.sv | 40 ++++
 rtl/i2s_master_tx.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/audipus_audio_pkg.sv
// Shared audio-path definitions: default sample/slot widths, transmitter state
// encoding and the word-select polarity constant.
package audipus_audio_pkg;

    localparam int DATA_W_DEF = 24;
    localparam int SLOT_W_DEF = 32;

    // Word-select level that marks the left channel.
    localparam logic LR_LEFT = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } i2s_state_e;

endpackage

// File: rtl/i2s_clk_div.sv
// Half-period clock divider: toggles div_clk every HALF enabled clk cycles and
// reports the toggle, rising and falling events as strobes for that same edge.
module i2s_clk_div #(
    parameter int HALF = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic div_clk,
    output logic tgl,
    output logic rise,
    output logic fall
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] cnt_q;

    // Strobes describe what div_clk does on the coming edge.
    assign tgl  = en && (cnt_q == CW'(HALF - 1));
    assign rise = tgl && !div_clk;
    assign fall = tgl && div_clk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            div_clk <= 1'b0;
        end else if (!en || clr) begin
            cnt_q   <= '0;
            div_clk <= 1'b0;
        end else if (tgl) begin
            cnt_q   <= '0;
            div_clk <= ~div_clk;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/i2s_master_tx.sv
// I2S master transmitter: generates sclk/bclk/lrclk and serializes 24-bit L/R PCM.
// Build option I2S_TX_UNDERRUN_MUTE_EN: on underrun send silence instead of the last sample.
module i2s_master_tx
    import audipus_audio_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int SLOT_W    = SLOT_W_DEF,
    parameter int BCLK_HALF = 4,
    parameter int SCLK_HALF = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     audio_en,
    input  logic                     l_data_en,
    input  logic                     r_data_en,
    input  logic signed [DATA_W-1:0] l_data,
    input  logic signed [DATA_W-1:0] r_data,
    output logic                     l_data_req,
    output logic                     r_data_req,
    output logic                     underrun,
    output logic                     busy,
    output logic                     sclk,
    output logic                     bclk,
    output logic                     lrclk,
    output logic                     s_data
);

    localparam int FRAME_W = 2 * SLOT_W;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

    i2s_state_e state_q, state_d;

    logic [CNT_W-1:0]         bit_cnt_q, bit_nxt, pos_nxt;
    logic signed [DATA_W-1:0] l_hold_q, r_hold_q, shift_q;
    logic signed [DATA_W-1:0] l_load_val, r_load_val;
    logic                     l_full_q, r_full_q;
    logic                     run_en, go_idle, load_l, load_r, shift_bit;
    logic                     bclk_tgl, bclk_rise, bclk_fall;
    logic                     sclk_tgl, sclk_rise, sclk_fall;
    logic                     unused_strobes;

    assign run_en         = (state_q != IDLE);
    assign unused_strobes = ^{bclk_tgl, bclk_rise, sclk_tgl, sclk_rise, sclk_fall};

    i2s_clk_div #(.HALF(BCLK_HALF)) u_bclk_div (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (run_en),
        .clr     (go_idle),
        .div_clk (bclk),
        .tgl     (bclk_tgl),
        .rise    (bclk_rise),
        .fall    (bclk_fall)
    );

    i2s_clk_div #(.HALF(SCLK_HALF)) u_sclk_div (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (run_en),
        .clr     (go_idle),
        .div_clk (sclk),
        .tgl     (sclk_tgl),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        bit_nxt   = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + CNT_W'(1);
        pos_nxt   = (bit_nxt >= CNT_W'(SLOT_W)) ? bit_nxt - CNT_W'(SLOT_W) : bit_nxt;
        // Draining stops on the frame wrap, so a stopped stream never starts a new left slot.
        go_idle   = (state_q == DRAIN) && !audio_en && bclk_fall && (bit_cnt_q == LAST_BIT);
        load_l    = bclk_fall && !go_idle && (bit_nxt == '0);
        load_r    = bclk_fall && (bit_nxt == CNT_W'(SLOT_W));
        shift_bit = bclk_fall && (pos_nxt >= CNT_W'(1)) && (pos_nxt <= CNT_W'(DATA_W));
`ifdef I2S_TX_UNDERRUN_MUTE_EN
        l_load_val = l_full_q ? l_hold_q : '0;
        r_load_val = r_full_q ? r_hold_q : '0;
`else
        l_load_val = l_hold_q;
        r_load_val = r_hold_q;
`endif
        state_d = state_q;
        case (state_q)
            IDLE:    if (audio_en) state_d = RUN;
            RUN:     if (!audio_en) state_d = DRAIN;
            DRAIN:   if (audio_en) state_d = RUN;
                     else if (go_idle) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= 1'b0;
            l_data_req <= 1'b0;
            r_data_req <= 1'b0;
            underrun   <= 1'b0;
            l_hold_q   <= '0;
            r_hold_q   <= '0;
            l_full_q   <= 1'b0;
            r_full_q   <= 1'b0;
            bit_cnt_q  <= LAST_BIT;
            lrclk      <= ~LR_LEFT;
            s_data     <= 1'b0;
        end else begin
            busy       <= (state_d != IDLE);
            l_data_req <= load_l && l_full_q;
            r_data_req <= load_r && r_full_q;
            underrun   <= (load_l && !l_full_q) || (load_r && !r_full_q);

            // A write coinciding with a load refills the hold, so it stays full.
            if (l_data_en) begin
                l_hold_q <= l_data;
                l_full_q <= 1'b1;
            end else if (load_l) begin
                l_full_q <= 1'b0;
            end
            if (r_data_en) begin
                r_hold_q <= r_data;
                r_full_q <= 1'b1;
            end else if (load_r) begin
                r_full_q <= 1'b0;
            end

            if (go_idle) begin
                bit_cnt_q <= LAST_BIT;
                lrclk     <= ~LR_LEFT;
                s_data    <= 1'b0;
            end else if (bclk_fall) begin
                bit_cnt_q <= bit_nxt;
                lrclk     <= (bit_nxt >= CNT_W'(SLOT_W)) ? ~LR_LEFT : LR_LEFT;
                s_data    <= shift_bit ? shift_q[DATA_W-1] : 1'b0;
            end
        end
    end

    // Serializer data path: slot position 0 loads, positions 1..DATA_W shift out MSB first.
    always_ff @(posedge clk) begin
        if (load_l)         shift_q <= l_load_val;
        else if (load_r)    shift_q <= r_load_val;
        else if (shift_bit) shift_q <= shift_q << 1;
    end

endmodule
